// File: rtl/audio_mixer_pwm.sv
// Audio mixer: internal sample strobe, muted/gained voice sum with saturation, double-buffered PWM.
// Optional error-feedback dither on the narrowing width map: define AUDIO_MIXER_DITHER_EN.
module audio_mixer_pwm #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int SAMPLE_RATE     = 16384,
  parameter int CHANNELS        = 4,
  parameter int IN_WIDTH        = 4,
  parameter int OUT_WIDTH       = 6,
  parameter int PWM_DIV         = 1
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic [CHANNELS*IN_WIDTH-1:0] samples_i,
  input  logic [CHANNELS-1:0]          mute_i,
  input  logic [1:0]                   gain_i,
  output logic                         sample_ena_o,
  output logic [OUT_WIDTH-1:0]         mix_o,
  output logic                         clip_o,
  output logic                         pwm_o
);

  localparam int DIV = CLOCK_FREQUENCY / SAMPLE_RATE;
  localparam int SCW = $clog2(DIV);
  localparam int SW  = IN_WIDTH + $clog2(CHANNELS);
  localparam int GW  = OUT_WIDTH + 4;
  localparam int PDW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [OUT_WIDTH-1:0] MIX_MAX = '1;

  logic [SCW-1:0]       cnt_q, cnt_d;
  logic                 ena_q, ena_d;
  logic [OUT_WIDTH-1:0] mix_q, mix_d;
  logic                 clip_q, clip_d;
  logic [PDW-1:0]       pre_q, pre_d;
  logic [OUT_WIDTH-1:0] pc_q, pc_d;
  logic [OUT_WIDTH-1:0] duty_q, duty_d;
  logic                 pwm_q, pwm_d;

  logic [SW-1:0]        sum;
  logic [OUT_WIDTH-1:0] norm;
  logic                 carry;
  logic [GW-1:0]        g;
  logic                 sat;
  logic                 tick;

  always_comb begin
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!mute_i[i]) sum = sum + SW'(samples_i[i*IN_WIDTH +: IN_WIDTH]);
    end
  end

  generate
    if (OUT_WIDTH >= SW) begin : g_widen
      assign norm  = OUT_WIDTH'(sum) << (OUT_WIDTH - SW);
      assign carry = 1'b0;
    end else begin : g_narrow
      localparam int DW = SW - OUT_WIDTH;
      assign norm = sum[SW-1:DW];
`ifdef AUDIO_MIXER_DITHER_EN
      // Accumulate the discarded LSBs; a carry out bumps this sample by one LSB.
      logic [DW-1:0] acc_q;
      logic [DW:0]   acc_sum;
      assign acc_sum = {1'b0, acc_q} + {1'b0, sum[DW-1:0]};
      assign carry   = acc_sum[DW];
      always_ff @(posedge clock_i) begin
        if (reset_i)    acc_q <= '0;
        else if (ena_q) acc_q <= acc_sum[DW-1:0];
      end
`else
      assign carry = 1'b0;
`endif
    end
  endgenerate

  // Extra headroom bit covers a dither increment on a full-scale sample.
  assign g   = (GW'(norm) + GW'(carry)) << gain_i;
  assign sat = g > GW'(MIX_MAX);

  assign tick = (pre_q == PDW'(PWM_DIV - 1));

  always_comb begin
    ena_d  = (cnt_q == SCW'(DIV - 1));
    cnt_d  = ena_d ? '0 : cnt_q + 1'b1;
    mix_d  = mix_q;
    clip_d = 1'b0;
    if (ena_q) begin
      mix_d  = sat ? MIX_MAX : g[OUT_WIDTH-1:0];
      clip_d = sat;
    end
    pre_d  = tick ? '0 : pre_q + 1'b1;
    pc_d   = pc_q;
    duty_d = duty_q;
    if (tick) begin
      pc_d = pc_q + 1'b1;
      // mix_q here is the pre-edge value, so a same-edge mix update waits a period.
      if (pc_q == MIX_MAX) duty_d = mix_q;
    end
    pwm_d = (pc_d < duty_d);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      ena_q  <= 1'b0;
      mix_q  <= '0;
      clip_q <= 1'b0;
      pre_q  <= '0;
      pc_q   <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ena_q  <= ena_d;
      mix_q  <= mix_d;
      clip_q <= clip_d;
      pre_q  <= pre_d;
      pc_q   <= pc_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign sample_ena_o = ena_q;
  assign mix_o        = mix_q;
  assign clip_o       = clip_q;
  assign pwm_o        = pwm_q;

endmodule

// File: tb/tb_audio_mixer_pwm.sv
// Directed bench for audio_mixer_pwm: strobe timing, mixing, saturation, PWM duty and double buffering.
module tb_audio_mixer_pwm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] samples = '0;
  logic [3:0]  mute = '0;
  logic [1:0]  gain = '0;

  logic        sample_ena, clip, pwm;
  logic [5:0]  mix;
  logic        ena1, clip1, pwm1;
  logic [5:0]  mix1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulse_q[$];
  int hi;

  always #5 clk = ~clk;

  audio_mixer_pwm u0 (
    .clock_i(clk), .reset_i(reset), .samples_i(samples), .mute_i(mute), .gain_i(gain),
    .sample_ena_o(sample_ena), .mix_o(mix), .clip_o(clip), .pwm_o(pwm)
  );

  audio_mixer_pwm #(.CLOCK_FREQUENCY(100), .SAMPLE_RATE(10), .PWM_DIV(3)) u1 (
    .clock_i(clk), .reset_i(reset), .samples_i(16'h4321), .mute_i(4'b0000), .gain_i(2'd0),
    .sample_ena_o(ena1), .mix_o(mix1), .clip_o(clip1), .pwm_o(pwm1)
  );

`ifdef AUDIO_MIXER_DITHER_EN
  logic       ena2, clip2, pwm2;
  logic [3:0] mix2;
  audio_mixer_pwm #(.CLOCK_FREQUENCY(100), .SAMPLE_RATE(10), .OUT_WIDTH(4)) u2 (
    .clock_i(clk), .reset_i(reset), .samples_i(16'h0002), .mute_i(4'b0000), .gain_i(2'd0),
    .sample_ena_o(ena2), .mix_o(mix2), .clip_o(clip2), .pwm_o(pwm2)
  );
`endif

  // Cycles since the last reset edge; the first non-reset edge makes this 1.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
  always @(negedge clk) if (sample_ena === 1'b1) pulse_q.push_back(cyc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ena(input string tag);
    int n = 0;
    while (sample_ena !== 1'b1 && n < 4000) begin
      step();
      n++;
    end
    check({tag, "_ena_seen"}, {31'd0, sample_ena}, 32'd1);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    repeat (3) step();
    check("rst_ena",  {31'd0, sample_ena}, 32'd0);
    check("rst_mix",  {26'd0, mix},        32'd0);
    check("rst_clip", {31'd0, clip},       32'd0);
    check("rst_pwm",  {31'd0, pwm},        32'd0);

    samples = 16'hFFFF; mute = 4'b0000; gain = 2'd0;
    reset = 1'b0;

    wait_ena("s1");
    check("s1_cyc", cyc, 32'd3051);
    step();
    check("mix_60",  {26'd0, mix},  32'd60);
    check("clip_60", {31'd0, clip}, 32'd0);

    mute = 4'b0101;
    wait_ena("s2");
    check("s2_cyc", cyc, 32'd6102);
    step();
    check("mix_mute", {26'd0, mix}, 32'd30);

    mute = 4'b0000; gain = 2'd1;
    wait_ena("s3");
    step();
    check("mix_sat",  {26'd0, mix},  32'd63);
    check("clip_hi",  {31'd0, clip}, 32'd1);
    step();
    check("clip_1cyc", {31'd0, clip}, 32'd0);

    samples = 16'h4444;
    wait_ena("s4");
    step();
    check("mix_32",  {26'd0, mix},  32'd32);
    check("clip_32", {31'd0, clip}, 32'd0);

    check("pulse_count", pulse_q.size(), 32'd4);
    if (pulse_q.size() >= 4) begin
      check("pulse0", pulse_q[0], 32'd3051);
      check("pulse1", pulse_q[1], 32'd6102);
      check("pulse2", pulse_q[2], 32'd9153);
      check("pulse3", pulse_q[3], 32'd12204);
    end

    // mix 32 -> 10 lands at PWM counter 24; old duty 32 must hold to period end.
    samples = 16'h4321; gain = 2'd0;
    wait_ena("s5");
    step();
    check("mix_10", {26'd0, mix}, 32'd10);
    check("mix_10_cyc", cyc, 32'd15256);
    wait_cyc(15260);
    check("old_duty_hold", {31'd0, pwm}, 32'd1);
    wait_cyc(15264);
    check("old_duty_end", {31'd0, pwm}, 32'd0);
    wait_cyc(15305);
    check("new_duty_hi", {31'd0, pwm}, 32'd1);
    step();
    check("new_duty_lo", {31'd0, pwm}, 32'd0);
    wait_cyc(15360);
    hi = 0;
    repeat (64) begin
      if (pwm === 1'b1) hi++;
      step();
    end
    check("pwm_duty10", hi, 32'd10);

    samples = 16'h0000;
    wait_ena("s6");
    step();
    check("mix_0", {26'd0, mix}, 32'd0);
    wait_cyc(18368);
    hi = 0;
    repeat (64) begin
      if (pwm === 1'b1) hi++;
      step();
    end
    check("pwm_duty0", hi, 32'd0);

    samples = 16'hFFFF; gain = 2'd1;
    wait_ena("s7");
    step();
    check("mix_63", {26'd0, mix}, 32'd63);
    wait_cyc(21376);
    hi = 0;
    repeat (64) begin
      if (pwm === 1'b1) hi++;
      step();
    end
    check("pwm_duty63", hi, 32'd63);

    wait_cyc(21450);
    check("pre_rst_pwm", {31'd0, pwm}, 32'd1);
    reset = 1'b1;
    step();
    check("mid_rst_pwm",  {31'd0, pwm},        32'd0);
    check("mid_rst_mix",  {26'd0, mix},        32'd0);
    check("mid_rst_clip", {31'd0, clip},       32'd0);
    check("mid_rst_ena",  {31'd0, sample_ena}, 32'd0);
    reset = 1'b0;
    wait_ena("post_rst");
    check("post_rst_cyc", cyc, 32'd3051);
    step();
    check("post_rst_mix", {26'd0, mix}, 32'd63);

    hi = 0;
    repeat (192) begin
      if (pwm1 === 1'b1) hi++;
      step();
    end
    check("pwm_div3", hi, 32'd30);
    check("u1_mix", {26'd0, mix1}, 32'd10);

`ifdef AUDIO_MIXER_DITHER_EN
    hi = 0;
    repeat (40) begin
      if (mix2 === 4'd1) hi++;
      step();
    end
    check("dither_avg", hi, 32'd20);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
